wallace_ppa_pipe: RTL and testbench
===================================

Name: wallace_ppa_pipe

Overview:
Parametrised, pipelined carry-save compressor tree. It reduces NUM_PP partial products of WIDTH bits to a redundant sum/carry pair using rows of 3:2 compressors, with a register after every reduction level. It carries a valid/ready handshake with full backpressure. It sits between the partial-product generator and the accumulator in the conv1d MAC datapath, and generalises the fixed 8-operand, 32-bit combinational compressor.

Parameters:
WIDTH, 32, bit width of each partial product and of all outputs (arithmetic mod 2^WIDTH)
NUM_PP, 8, number of partial products; legal range 3..16
LEVELS, csa_levels(NUM_PP), number of 3:2 reduction levels; derived, not overridden (8 -> 4, 16 -> 6)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of all pipeline valids
in_valid  in  1  pp bus holds a valid operand set
in_ready  out  1  block accepts pp this cycle
pp  in  WIDTH*NUM_PP  partial products; PP[k] = pp[k*WIDTH +: WIDTH]
out_valid  out  1  out_sum/out_carry valid
out_ready  in  1  downstream accepts output
out_sum  out  WIDTH  redundant sum word
out_carry  out  WIDTH  redundant carry word, already weighted (shifted)
out_result  out  WIDTH  out_sum + out_carry mod 2^WIDTH; see Optional Feature

Behaviour:
- One clock, clk; reset rst is asynchronous and active-high. Reset clears every stage valid bit and every data register to 0, so out_valid=0, out_sum=0, out_carry=0, out_result=0. in_ready=1 after reset.
- Level reduction: each level groups the current operands in threes, in index order. Each full group of three feeds one 3:2 row: sum = a^b^c, carry = maj(a,b,c) << 1, with carry bit 0 = 0 and the MSB carry dropped. Leftover operands (1 or 2) pass through unchanged. Per level, n -> 2*floor(n/3) + (n mod 3), repeated until 2 remain.
- Invariant: out_sum + out_carry == sum of all PP[k], mod 2^WIDTH.
- Pipeline: LEVELS register stages, one per level. Latency is LEVELS cycles from acceptance to out_valid when there is no stall (8 -> 4 cycles).
- Stage advance: stage s loads from s-1 when (valid[s-1] and (!valid[s] or stage s advancing)). The last stage advances when out_ready=1. in_ready = !valid[0] or stage 0 advancing. Bubbles collapse. Throughput is 1 per cycle with out_ready held high.
- out_valid held with out_ready=0: out_sum/out_carry/out_result stay stable, and upstream fills until in_ready=0. No data is dropped or duplicated.
- Simultaneous accept and output in the same cycle is legal in every stage when full.
- flush=1: all valid bits cleared at the next edge and input that cycle is not accepted (in_ready forced 0). Data registers may keep stale values. flush has priority over handshake.
- rst asserted mid-operation: in-flight data is discarded immediately (asynchronous); the pipeline is empty on release.
- Data registers load only on stage advance, not on every clock.

Optional Feature:
Macro WALLACE_CPA_EN.
- Defined: one extra register stage holding a carry-propagate adder result. Latency is LEVELS+1. out_sum/out_carry are delayed to stay aligned with out_result. out_result = out_sum + out_carry mod 2^WIDTH.
- Undefined: no adder, latency LEVELS, out_result tied to 0.

Decomposition:
- Package wallace_pkg: function csa_levels(n), a per-level operand-count function csa_count(n, lvl), and the legal NUM_PP bounds (MIN_PP=3, MAX_PP=16).
- Sub-module csa_row: combinational, parameters WIDTH and N_IN. Reduces N_IN operands by one level and outputs csa_count(N_IN,1) operands, with the shifted-carry rule applied.
- The top generates LEVELS instances of csa_row with the stage registers between them.

Test Plan:
1. NUM_PP=8, WIDTH=32, all PP[k]=1, out_ready=1 -> after 4 cycles out_valid=1, out_sum+out_carry=8; out_result=8 with WALLACE_CPA_EN.
2. All PP[k]=32'hFFFF_FFFF -> out_sum+out_carry mod 2^32 = 32'hFFFF_FFF8; carry bit 0 is always 0.
3. 20 back-to-back random sets, out_ready=1 -> one output per cycle, in order, each matching the reference sum.
4. out_ready=0 for 10 cycles while streaming -> in_ready falls after 4 accepts, held output stable. Release gives all 4 plus subsequent sets in order, with no loss.
5. flush pulse with 3 sets in flight -> no out_valid for those sets; the next accepted set emerges with latency 4.
6. rst asserted mid-stream at an arbitrary phase -> out_valid=0 and outputs 0 immediately. NUM_PP=3 and NUM_PP=16 builds give latency 1 and 6 respectively with correct sums.

Source files
------------

// File: rtl/wallace_pkg.sv
// Sizing helpers for the pipelined carry-save compressor tree: operand counts per
// reduction level and the number of levels needed to reach a sum/carry pair.
package wallace_pkg;

    localparam int MIN_PP = 3;
    localparam int MAX_PP = 16;

    // Operands left after lvl levels of 3:2 reduction starting from n.
    function automatic int csa_count(input int n, input int lvl);
        int c;
        c = n;
        for (int i = 0; i < lvl; i++) begin
            if (c > 2) c = 2 * (c / 3) + (c % 3);
        end
        return c;
    endfunction

    function automatic int csa_levels(input int n);
        int c;
        int l;
        c = n;
        l = 0;
        while (c > 2) begin
            c = 2 * (c / 3) + (c % 3);
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/wallace_ppa_pipe_csa_row.sv
// One combinational 3:2 reduction level: operands are grouped in threes in index
// order, each group yields sum then shifted carry; 1-2 leftovers pass through.
module csa_row
    import wallace_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  N_IN  = 3,
    localparam int N_OUT = csa_count(N_IN, 1)
) (
    input  logic [N_IN*WIDTH-1:0]  opnd,
    output logic [N_OUT*WIDTH-1:0] red
);

    localparam int GROUPS = N_IN / 3;
    localparam int REM    = N_IN % 3;

    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
        logic [WIDTH-1:0] a, b, c, maj;
        assign a   = opnd[(3*g)*WIDTH   +: WIDTH];
        assign b   = opnd[(3*g+1)*WIDTH +: WIDTH];
        assign c   = opnd[(3*g+2)*WIDTH +: WIDTH];
        assign maj = (a & b) | (a & c) | (b & c);
        assign red[(2*g)*WIDTH +: WIDTH]   = a ^ b ^ c;
        // Carry is weighted by one bit; the MSB carry falls off (mod 2^WIDTH).
        assign red[(2*g+1)*WIDTH +: WIDTH] = maj << 1;
    end

    for (genvar r = 0; r < REM; r++) begin : g_pass
        assign red[(2*GROUPS+r)*WIDTH +: WIDTH] = opnd[(3*GROUPS+r)*WIDTH +: WIDTH];
    end

endmodule

// File: rtl/wallace_ppa_pipe.sv
// Pipelined carry-save compressor tree with valid/ready backpressure, one register
// per reduction level. Define WALLACE_CPA_EN to add a final carry-propagate stage.
module wallace_ppa_pipe
    import wallace_pkg::*;
#(
    parameter int  WIDTH  = 32,
    parameter int  NUM_PP = 8,
    localparam int LEVELS = csa_levels(NUM_PP)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH*NUM_PP-1:0] pp,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_sum,
    output logic [WIDTH-1:0]        out_carry,
    output logic [WIDTH-1:0]        out_result
);

`ifdef WALLACE_CPA_EN
    localparam int STAGES = LEVELS + 1;
`else
    localparam int STAGES = LEVELS;
`endif

    logic [STAGES-1:0] vld_pipe;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic              bub;

    // A stage moves on when the sink takes data or any later stage has a hole;
    // written without a recursive chain so the ready path stays acyclic.
    always_comb begin
        adv = '0;
        bub = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            bub = out_ready;
            for (int j = s + 1; j < STAGES; j++) bub = bub | !vld_pipe[j];
            adv[s] = vld_pipe[s] & bub;
        end
    end

    assign in_ready = !flush && (!vld_pipe[0] || adv[0]);

    always_comb begin
        load    = '0;
        load[0] = in_valid & in_ready;
        for (int s = 1; s < STAGES; s++) load[s] = adv[s-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        vld_pipe <= '0;
        else if (flush) vld_pipe <= '0;
        else            vld_pipe <= load | (vld_pipe & ~adv);
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int N_IN  = csa_count(NUM_PP, l);
        localparam int N_OUT = csa_count(NUM_PP, l + 1);
        logic [N_IN*WIDTH-1:0]  d;
        logic [N_OUT*WIDTH-1:0] r;
        logic [N_OUT*WIDTH-1:0] q;

        if (l == 0) begin : g_src
            assign d = pp;
        end else begin : g_src
            assign d = g_lvl[l-1].q;
        end

        csa_row #(.WIDTH(WIDTH), .N_IN(N_IN)) u_row (
            .opnd (d),
            .red  (r)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst)          q <= '0;
            else if (load[l]) q <= r;
        end
    end

    logic [WIDTH-1:0] fin_sum;
    logic [WIDTH-1:0] fin_carry;
    assign fin_sum   = g_lvl[LEVELS-1].q[WIDTH-1:0];
    assign fin_carry = g_lvl[LEVELS-1].q[2*WIDTH-1:WIDTH];

`ifdef WALLACE_CPA_EN
    logic [WIDTH-1:0] cpa_sum, cpa_carry, cpa_res;

    // Redundant pair is re-registered alongside the adder so all three outputs align.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpa_sum   <= '0;
            cpa_carry <= '0;
            cpa_res   <= '0;
        end else if (load[LEVELS]) begin
            cpa_sum   <= fin_sum;
            cpa_carry <= fin_carry;
            cpa_res   <= fin_sum + fin_carry;
        end
    end

    assign out_sum    = cpa_sum;
    assign out_carry  = cpa_carry;
    assign out_result = cpa_res;
`else
    assign out_sum    = fin_sum;
    assign out_carry  = fin_carry;
    assign out_result = '0;
`endif

    assign out_valid = vld_pipe[STAGES-1];

endmodule

// File: tb/tb_wallace_ppa_pipe.sv
// Directed bench for wallace_ppa_pipe: NUM_PP=8 main instance plus NUM_PP=3/16 builds.
module tb_wallace_ppa_pipe;

    localparam int W = 32;
`ifdef WALLACE_CPA_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT8  = 4 + EXTRA;
    localparam int LAT3  = 1 + EXTRA;
    localparam int LAT16 = 6 + EXTRA;

    logic clk = 1'b0;
    logic rst, flush;

    logic iv8, ir8, ov8, or8;
    logic [8*W-1:0] pp8;
    logic [W-1:0] s8, c8, r8;

    logic iv3, ir3, ov3, or3;
    logic [3*W-1:0] pp3;
    logic [W-1:0] s3, c3, r3;

    logic iv16, ir16, ov16, or16;
    logic [16*W-1:0] pp16;
    logic [W-1:0] s16, c16, r16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wallace_ppa_pipe #(.WIDTH(W), .NUM_PP(8)) dut8 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv8), .in_ready(ir8), .pp(pp8),
        .out_valid(ov8), .out_ready(or8), .out_sum(s8), .out_carry(c8), .out_result(r8)
    );
    wallace_ppa_pipe #(.WIDTH(W), .NUM_PP(3)) dut3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv3), .in_ready(ir3), .pp(pp3),
        .out_valid(ov3), .out_ready(or3), .out_sum(s3), .out_carry(c3), .out_result(r3)
    );
    wallace_ppa_pipe #(.WIDTH(W), .NUM_PP(16)) dut16 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv16), .in_ready(ir16), .pp(pp16),
        .out_valid(ov16), .out_ready(or16), .out_sum(s16), .out_carry(c16), .out_result(r16)
    );

    function automatic logic [W-1:0] sum_pp8(input logic [8*W-1:0] p);
        logic [W-1:0] s;
        s = '0;
        for (int k = 0; k < 8; k++) s = s + p[k*W +: W];
        return s;
    endfunction

    function automatic logic [W-1:0] exp_res(input logic [W-1:0] e);
        return (EXTRA != 0) ? e : '0;
    endfunction

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        iv8 = 0; iv3 = 0; iv16 = 0; or8 = 1; or3 = 1; or16 = 1;
        pp8 = '0; pp3 = '0; pp16 = '0;
        #12;
        n_cmp++; if ({ov8, ov3, ov16} !== 3'b000) begin n_err++; $display("FAIL reset_valid got=%b want=000", {ov8, ov3, ov16}); end
        n_cmp++; if (s8 !== '0 || c8 !== '0) begin n_err++; $display("FAIL reset_data sum=%h carry=%h want 0", s8, c8); end
        n_cmp++; if (r8 !== '0) begin n_err++; $display("FAIL reset_result got=%h want 0", r8); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (ir8 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want 1", ir8); end
    endtask

    task automatic test_directed8();
        logic [W-1:0] vals [3];
        logic [W-1:0] exps [3];
        vals = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h2000_0000};
        exps = '{32'h0000_0008, 32'hFFFF_FFF8, 32'h0000_0000};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pp8 = {8{vals[i]}}; iv8 = 1'b1; or8 = 1'b1;
            @(negedge clk);
            iv8 = 1'b0;
            for (int k = 1; k < LAT8; k++) begin
                n_cmp++; if (ov8 !== 1'b0) begin n_err++; $display("FAIL dir_early[%0d] k=%0d out_valid=%b want 0", i, k, ov8); end
                @(negedge clk);
            end
            n_cmp++; if (ov8 !== 1'b1) begin n_err++; $display("FAIL dir_lat[%0d] out_valid=%b want 1", i, ov8); end
            n_cmp++; if (s8 + c8 !== exps[i]) begin n_err++; $display("FAIL dir_sum[%0d] got=%h want=%h", i, s8 + c8, exps[i]); end
            n_cmp++; if (c8[0] !== 1'b0) begin n_err++; $display("FAIL dir_carry0[%0d] got=%b want 0", i, c8[0]); end
            n_cmp++; if (r8 !== exp_res(exps[i])) begin n_err++; $display("FAIL dir_result[%0d] got=%h want=%h", i, r8, exp_res(exps[i])); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q [$];
        int sent = 0, got = 0, first = -1, last = -1;
        @(negedge clk);
        or8 = 1'b1;
        for (int c = 0; c < 100 && got < 20; c++) begin
            if (ov8) begin
                if (q.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL b2b_extra cycle=%0d unexpected output sum=%h", c, s8 + c8);
                end else begin
                    n_cmp++; if (s8 + c8 !== q[0]) begin n_err++; $display("FAIL b2b_sum[%0d] got=%h want=%h", got, s8 + c8, q[0]); end
                    n_cmp++; if (r8 !== exp_res(q[0])) begin n_err++; $display("FAIL b2b_result[%0d] got=%h want=%h", got, r8, exp_res(q[0])); end
                    void'(q.pop_front());
                end
                got++;
                if (first < 0) first = c;
                last = c;
            end
            if (sent < 20) begin
                for (int k = 0; k < 8; k++) pp8[k*W +: W] = $urandom;
                iv8 = 1'b1;
            end else iv8 = 1'b0;
            #1;
            if (iv8 && ir8) begin q.push_back(sum_pp8(pp8)); sent++; end
            @(negedge clk);
        end
        iv8 = 1'b0;
        n_cmp++; if (got != 20) begin n_err++; $display("FAIL b2b_count got=%0d want=20", got); end
        n_cmp++; if (last - first != 19) begin n_err++; $display("FAIL b2b_rate span=%0d want=19", last - first); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] q [$];
        logic [W-1:0] held_s, held_c;
        logic have_held = 1'b0;
        int sent = 0, got = 0, acc_stall = 0;
        for (int c = 0; c < 200 && got < 10; c++) begin
            or8 = (c >= 10);
            if (ov8) begin
                if (q.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL bp_extra cycle=%0d unexpected output", c);
                end else begin
                    n_cmp++; if (s8 + c8 !== q[0]) begin n_err++; $display("FAIL bp_sum cycle=%0d got=%h want=%h", c, s8 + c8, q[0]); end
                end
                if (or8) begin
                    if (q.size() != 0) void'(q.pop_front());
                    got++;
                end else if (have_held) begin
                    n_cmp++; if (s8 !== held_s || c8 !== held_c) begin n_err++; $display("FAIL bp_hold cycle=%0d sum=%h carry=%h want %h %h", c, s8, c8, held_s, held_c); end
                end else begin
                    held_s = s8; held_c = c8; have_held = 1'b1;
                end
            end
            if (sent < 10) begin
                for (int k = 0; k < 8; k++) pp8[k*W +: W] = W'(32'h0101_0000 * (sent + 1) + k);
                iv8 = 1'b1;
            end else iv8 = 1'b0;
            #1;
            if (iv8 && ir8) begin
                q.push_back(sum_pp8(pp8)); sent++;
                if (c < 10) acc_stall++;
            end
            if (c == 9) begin
                n_cmp++; if (ir8 !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got=%b want 0", ir8); end
            end
            @(negedge clk);
        end
        iv8 = 1'b0; or8 = 1'b1;
        n_cmp++; if (acc_stall != LAT8) begin n_err++; $display("FAIL bp_accepts got=%0d want=%0d", acc_stall, LAT8); end
        n_cmp++; if (got != 10 || q.size() != 0) begin n_err++; $display("FAIL bp_drain got=%0d left=%0d want 10/0", got, q.size()); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        or8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pp8 = {8{W'(i + 5)}}; iv8 = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (ov8 !== 1'b0) begin n_err++; $display("FAIL fl_pre out_valid=%b want 0", ov8); end
        flush = 1'b1; pp8 = {8{32'h0000_0077}}; iv8 = 1'b1;
        #1;
        n_cmp++; if (ir8 !== 1'b0) begin n_err++; $display("FAIL fl_in_ready got=%b want 0", ir8); end
        @(negedge clk);
        flush = 1'b0; iv8 = 1'b0;
        n_cmp++; if (ov8 !== 1'b0) begin n_err++; $display("FAIL fl_clear out_valid=%b want 0", ov8); end
        pp8 = {8{32'h1234_5678}}; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        for (int k = 1; k < LAT8; k++) begin
            n_cmp++; if (ov8 !== 1'b0) begin n_err++; $display("FAIL fl_ghost k=%0d out_valid=%b want 0", k, ov8); end
            @(negedge clk);
        end
        n_cmp++; if (ov8 !== 1'b1) begin n_err++; $display("FAIL fl_lat out_valid=%b want 1", ov8); end
        n_cmp++; if (s8 + c8 !== 32'h91A2_B3C0) begin n_err++; $display("FAIL fl_sum got=%h want=91a2b3c0", s8 + c8); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++; if (ov8 !== 1'b0) begin n_err++; $display("FAIL fl_tail k=%0d out_valid=%b want 0", k, ov8); end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        or8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pp8 = {8{W'(32'h0003_0000 + i)}}; iv8 = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (ov8 !== 1'b1) begin n_err++; $display("FAIL rm_busy out_valid=%b want 1", ov8); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (ov8 !== 1'b0) begin n_err++; $display("FAIL rm_valid got=%b want 0", ov8); end
        n_cmp++; if (s8 !== '0 || c8 !== '0 || r8 !== '0) begin n_err++; $display("FAIL rm_data sum=%h carry=%h res=%h want 0", s8, c8, r8); end
        iv8 = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (ir8 !== 1'b1) begin n_err++; $display("FAIL rm_in_ready got=%b want 1", ir8); end
        for (int k = 0; k < LAT8 + 2; k++) begin
            @(negedge clk);
            n_cmp++; if (ov8 !== 1'b0) begin n_err++; $display("FAIL rm_empty k=%0d out_valid=%b want 0", k, ov8); end
        end
    endtask

    task automatic test_pp3();
        logic [3*W-1:0] vecs [2];
        logic [W-1:0]   exps [2];
        vecs = '{{32'd9, 32'd7, 32'd5}, {32'd2, 32'd1, 32'hFFFF_FFFF}};
        exps = '{32'd21, 32'd2};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            pp3 = vecs[i]; iv3 = 1'b1; or3 = 1'b1;
            @(negedge clk);
            iv3 = 1'b0;
            for (int k = 1; k < LAT3; k++) begin
                n_cmp++; if (ov3 !== 1'b0) begin n_err++; $display("FAIL pp3_early[%0d] k=%0d out_valid=%b want 0", i, k, ov3); end
                @(negedge clk);
            end
            n_cmp++; if (ov3 !== 1'b1) begin n_err++; $display("FAIL pp3_lat[%0d] out_valid=%b want 1", i, ov3); end
            n_cmp++; if (s3 + c3 !== exps[i]) begin n_err++; $display("FAIL pp3_sum[%0d] got=%h want=%h", i, s3 + c3, exps[i]); end
            n_cmp++; if (r3 !== exp_res(exps[i])) begin n_err++; $display("FAIL pp3_result[%0d] got=%h want=%h", i, r3, exp_res(exps[i])); end
        end
    endtask

    task automatic test_pp16();
        logic [W-1:0] exps [2];
        exps = '{32'h0000_0088, 32'hFFFF_FFF0};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            for (int k = 0; k < 16; k++) pp16[k*W +: W] = (i == 0) ? W'(k + 1) : 32'hFFFF_FFFF;
            iv16 = 1'b1; or16 = 1'b1;
            @(negedge clk);
            iv16 = 1'b0;
            for (int k = 1; k < LAT16; k++) begin
                n_cmp++; if (ov16 !== 1'b0) begin n_err++; $display("FAIL pp16_early[%0d] k=%0d out_valid=%b want 0", i, k, ov16); end
                @(negedge clk);
            end
            n_cmp++; if (ov16 !== 1'b1) begin n_err++; $display("FAIL pp16_lat[%0d] out_valid=%b want 1", i, ov16); end
            n_cmp++; if (s16 + c16 !== exps[i]) begin n_err++; $display("FAIL pp16_sum[%0d] got=%h want=%h", i, s16 + c16, exps[i]); end
            n_cmp++; if (c16[0] !== 1'b0) begin n_err++; $display("FAIL pp16_carry0[%0d] got=%b want 0", i, c16[0]); end
            n_cmp++; if (r16 !== exp_res(exps[i])) begin n_err++; $display("FAIL pp16_result[%0d] got=%h want=%h", i, r16, exp_res(exps[i])); end
        end
    endtask

    initial begin
        test_reset();
        test_directed8();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_pp3();
        test_pp16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
